// File: rtl/sic4_pkg.sv
// Shared SIC-4 core definitions: datapath widths, reset vector and fetch FSM states.
package sic4_pkg;

  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH = 8;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    FETCH_HI,
    FETCH_LO,
    VALID
  } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register: async reset, branch load and byte increment.
// Load wins over increment, and the increment wraps at WIDTH bits.
module program_counter #(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_VAL;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + WIDTH'(1);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// SIC-4 fetch stage: walks the byte ROM with the PC and assembles 16-bit
// {opcode, operand} instructions for decode over a valid/ready handshake.
module instr_fetch
  import sic4_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = sic4_pkg::ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH = sic4_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = sic4_pkg::RESET_PC
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  input  logic [DATA_WIDTH-1:0]   imem_data,
  output logic [2*DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]   instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  input  logic                    branch_en,
  input  logic [ADDR_WIDTH-1:0]   branch_target,
  input  logic                    halt
);

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] ir_hi;
  logic [ADDR_WIDTH-1:0] start_pc;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pc_inc;

  // The PC advances on every cycle that captures a ROM byte.
  always_comb begin
    pc_inc = 1'b0;
    if (!branch_en) begin
      unique case (state)
        FETCH_HI: pc_inc = !halt;
        FETCH_LO: pc_inc = 1'b1;
        VALID:    pc_inc = instr_ready && !halt;
        default:  pc_inc = 1'b0;
      endcase
    end
  end

  program_counter #(
    .WIDTH    (ADDR_WIDTH),
    .RESET_VAL(RESET_PC)
  ) u_program_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (branch_en),
    .load_value(branch_target),
    .inc       (pc_inc),
    .pc        (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH_HI;
      ir_hi       <= '0;
      start_pc    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (branch_en) begin
      // Redirect drops any half-fetched opcode byte and any pending instruction.
      state       <= FETCH_HI;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        FETCH_HI: begin
          if (!halt) begin
            ir_hi    <= imem_data;
            start_pc <= pc;
            state    <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          instr       <= {ir_hi, imem_data};
          instr_pc    <= start_pc;
          instr_valid <= 1'b1;
          state       <= VALID;
        end
        VALID: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (!halt) begin
              // Overlap: the next opcode byte is captured during the handshake.
              ir_hi    <= imem_data;
              start_pc <= pc;
              state    <= FETCH_LO;
            end else begin
              state <= FETCH_HI;
            end
          end
        end
        default: state <= FETCH_HI;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage of the SIC-4 core, directly upstream of instr_memory.
- Owns the program counter and drives the address of the combinational instruction ROM.
- Assembles each 16-bit instruction from two consecutive 8-bit ROM bytes: opcode byte, then operand byte.
- Presents the instruction to decode over a valid/ready handshake, with branch redirect and halt control.

Parameters:
ADDR_WIDTH, 8, ROM address / PC width
DATA_WIDTH, 8, ROM byte width; instruction width is 2*DATA_WIDTH
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_addr  out  ADDR_WIDTH  address to instr_memory; equals the PC register output (no combinational path from inputs)
imem_data  in  DATA_WIDTH  byte returned combinationally by instr_memory for imem_addr
instr  out  2*DATA_WIDTH  {opcode byte, operand byte}
instr_pc  out  ADDR_WIDTH  address of the opcode byte of instr
instr_valid  out  1  instr/instr_pc hold a complete instruction
instr_ready  in  1  decode accepts instr this cycle when instr_valid=1
branch_en  in  1  redirect fetch this cycle
branch_target  in  ADDR_WIDTH  new PC when branch_en=1
halt  in  1  suppress starting new instruction fetches

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=FETCH_HI, instr=0, instr_pc=0, instr_valid=0, ir_hi=0, start_pc=0.
- All outputs are registered. PC increments by 1 per byte captured and wraps 8'hFF->8'h00 (mod 2^ADDR_WIDTH).
- States:
  - FETCH_HI: if !halt: ir_hi<=imem_data, start_pc<=pc, pc<=pc+1, go to FETCH_LO. If halt: hold with pc unchanged.
  - FETCH_LO: instr<={ir_hi,imem_data}, instr_pc<=start_pc, instr_valid<=1, pc<=pc+1, go to VALID. halt is ignored; a started instruction always completes.
  - VALID: instr, instr_pc and instr_valid are held stable while instr_ready=0.
    - ready=1 & !halt: instr_valid<=0, ir_hi<=imem_data, start_pc<=pc, pc<=pc+1, go to FETCH_LO. Overlapped fetch gives 1 instr per 2 cycles under continuous ready.
    - ready=1 & halt: instr_valid<=0, go to FETCH_HI with pc unchanged.
- Latency: from reset release (or a redirect), the first instr_valid rises at the 2nd rising edge.
- Branch (branch_en=1) has highest priority in every state:
  - pc<=branch_target, state<=FETCH_HI, instr_valid<=0; any partially fetched byte is discarded.
  - In VALID with ready=1 in the same cycle, the handshake counts as completed and the redirect still applies.
  - branch_en with halt=1: pc loads the target and fetch remains halted.
- instr and instr_pc keep their last values when instr_valid=0; decode must not sample them.
- Reset asserted mid-operation overrides every state. Deassertion resumes in FETCH_HI at RESET_PC.

Decomposition:
- Shared package sic4_pkg holds:
  - ADDR_WIDTH/DATA_WIDTH constants
  - fetch_state_t enum {FETCH_HI, FETCH_LO, VALID} (2-bit)
  - RESET_PC constant
- One sub-module, program_counter:
  - Register with async reset, load (branch) and increment enables.
  - Load has priority over increment; wraps naturally at ADDR_WIDTH.
  - The FSM and output registers stay in instr_fetch.

Test Plan:
- ROM[0..3]=12,34,56,78, ready=1 held, reset released -> edge 2: instr=16'h1234, instr_pc=00, valid=1; edge 4: instr=16'h5678, instr_pc=02; imem_addr sequence 00,01,02,03,04.
- Same ROM, ready=0 for 5 cycles after first valid -> instr=16'h1234 and valid=1 stable, imem_addr=02 frozen; ready=1 -> next edge valid=0, following edge instr=16'h5678.
- branch_en=1, target=8'h40 during FETCH_LO of the instr at 00 -> no valid for 00, valid=0 next cycle; next instr_pc=40, instr={ROM[40],ROM[41]}.
- branch to 8'hFE, ROM[FE]=AA, ROM[FF]=BB, ROM[00]=CC, ROM[01]=DD -> instr=16'hAABB with instr_pc=FE, then 16'hCCDD with instr_pc=00 (PC wrap).
- halt=1 raised during FETCH_LO -> that instr still becomes valid; after the handshake no further valid, imem_addr frozen at next PC; halt=0 -> fetch resumes from that address.
- rst=1 asserted asynchronously mid-cycle while valid=1 -> instr_valid, instr and instr_pc go to 0 and imem_addr to 00 before the next clock edge; after release, the first instr comes from 00.
